// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit:
// condition encodings and counter constants.
package bru_pkg;

    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_LTZ    = 3'd2;
    localparam logic [2:0] COND_GEZ    = 3'd3;
    localparam logic [2:0] COND_LEZ    = 3'd4;
    localparam logic [2:0] COND_GTZ    = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    function automatic int cnt_wnt_f(int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int cnt_max_f(int w);
        return (1 << w) - 1;
    endfunction

    // Values for the default 2-bit counter width.
    localparam int CNT_W_DEF = 2;
    localparam logic [CNT_W_DEF-1:0] CNT_WNT = 2'b01;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = 2'b11;

endpackage

// File: rtl/bru_bht.sv
// Direct-mapped table of saturating counters with a
// combinational read port and one saturating write port.
import bru_pkg::*;

module bru_bht #(
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W = 2,
    localparam int IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_up
);

    localparam logic [CNT_W-1:0] RST_V = CNT_W'(cnt_wnt_f(CNT_W));
    localparam logic [CNT_W-1:0] TOP_V = CNT_W'(cnt_max_f(CNT_W));
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

    logic [CNT_W-1:0] cnt [BHT_DEPTH];
    logic [CNT_W-1:0] cur;

    assign cur = cnt[wr_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt[i] <= RST_V;
            end
        end else if (wr_en) begin
            if (wr_up && cur != TOP_V) begin
                cnt[wr_idx] <= cur + ONE_V;
            end else if (!wr_up && cur != '0) begin
                cnt[wr_idx] <= cur - ONE_V;
            end
        end
    end

    // Read sees the pre-update value on a same-index write.
    assign rd_taken = cnt[rd_idx][CNT_W-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with BHT training and mispredict flush.
// Optional statistics counters built when BRU_STATS_EN is defined.
import bru_pkg::*;

module branch_resolve_unit #(
    parameter int PC_W = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic [2:0]        ex_cond,
    input  logic              ex_zero,
    input  logic              ex_neg,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_pred_taken,
    input  logic              ex_stall,
    output logic              mem_pcsrc,
    output logic              mem_flush,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic resolve;
    logic cond;
    logic taken;
    logic mispredict;

    always_comb begin
        cond = 1'b0;
        unique case (ex_cond)
            COND_EQ:     cond = ex_zero;
            COND_NE:     cond = !ex_zero;
            COND_LTZ:    cond = ex_neg;
            COND_GEZ:    cond = !ex_neg;
            COND_LEZ:    cond = ex_neg | ex_zero;
            COND_GTZ:    cond = !ex_neg & !ex_zero;
            COND_ALWAYS: cond = 1'b1;
            COND_NEVER:  cond = 1'b0;
        endcase
    end

    assign resolve    = ex_valid & ex_branch & !ex_stall;
    assign taken      = resolve & cond;
    assign mispredict = resolve & (cond != ex_pred_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_pcsrc <= 1'b0;
            mem_flush <= 1'b0;
        end else begin
            mem_pcsrc <= taken;
            mem_flush <= mispredict;
        end
    end

    bru_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_W     (CNT_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_taken (if_pred_taken),
        .wr_en    (resolve),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_up    (cond)
    );

`ifdef BRU_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve && !(&stat_branches)) begin
                stat_branches <= stat_branches + STAT_ONE;
            end
            if (mispredict && !(&stat_mispredicts)) begin
                stat_mispredicts <= stat_mispredicts + STAT_ONE;
            end
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

    // PC bits outside the table index do not affect the lookup.
    logic unused_pc;
    assign unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                         ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit against a
// behavioural model of the condition table, BHT and stats.
import bru_pkg::*;

module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic [2:0]  ex_cond;
    logic        ex_zero;
    logic        ex_neg;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_stall;
    logic        mem_pcsrc;
    logic        mem_flush;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;

    int chk = 0;
    int err = 0;

    int bht [16];
    bit ep, ef;
    int sb, sm;

    branch_resolve_unit #(
        .PC_W (32), .BHT_DEPTH (16), .CNT_W (2), .STAT_W (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_cond          (ex_cond),
        .ex_zero          (ex_zero),
        .ex_neg           (ex_neg),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_stall         (ex_stall),
        .mem_pcsrc        (mem_pcsrc),
        .mem_flush        (mem_flush),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_of(logic [2:0] c, bit z, bit n);
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return n;
            3'd3: return !n;
            3'd4: return n || z;
            3'd5: return !n && !z;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_pred(logic [31:0] pc);
        return bht[int'(pc[5:2])] >= 2;
    endfunction

    function automatic void model_edge();
        bit res, c;
        int i;
        if (reset) begin
            foreach (bht[k]) bht[k] = 1;
            ep = 0; ef = 0; sb = 0; sm = 0;
        end else begin
            res = ex_valid && ex_branch && !ex_stall;
            c = cond_of(ex_cond, ex_zero, ex_neg);
            ep = res && c;
            ef = res && (c != ex_pred_taken);
            if (res) begin
                i = int'(ex_pc[5:2]);
                if (c) bht[i] = (bht[i] == 3) ? 3 : bht[i] + 1;
                else   bht[i] = (bht[i] == 0) ? 0 : bht[i] - 1;
                if (sb < 15) sb++;
                if (ef && sm < 15) sm++;
            end
        end
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [3:0] b, m;
`ifdef BRU_STATS_EN
        b = 4'(sb); m = 4'(sm);
`else
        b = 4'd0; m = 4'd0;
`endif
        return {model_pred(if_pc), ep, ef, b, m};
    endfunction

    logic [10:0] obs;
    assign obs = {if_pred_taken, mem_pcsrc, mem_flush,
                  stat_branches, stat_mispredicts};

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; ex_valid = 0; ex_branch = 0; ex_cond = 3'd0;
        ex_zero = 0; ex_neg = 0; ex_pred_taken = 0; ex_stall = 0;
    endtask

    task automatic br(logic [31:0] pc, logic [2:0] c, bit z, bit n, bit p);
        ex_valid = 1; ex_branch = 1; ex_stall = 0; ex_pc = pc;
        ex_cond = c; ex_zero = z; ex_neg = n; ex_pred_taken = p;
    endtask

    task automatic test_reset();
        idle(); reset = 1; if_pc = 32'h40; ex_pc = 32'h0;
        tick(); tick();
        reset = 0;
        #1;
        chk++;
        if (obs !== 11'd0) begin
            err++; $display("FAIL reset got=%h exp=%h", obs, 11'd0);
        end
        chk++;
        if (obs !== exp_vec()) begin
            err++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_taken();
        br(32'h40, COND_EQ, 1, 0, 0);
        tick();
        idle();
        chk++;
        if ({mem_pcsrc, mem_flush} !== 2'b11) begin
            err++; $display("FAIL taken_pulse got=%b exp=11", {mem_pcsrc, mem_flush});
        end
        tick();
        chk++;
        if ({mem_pcsrc, mem_flush} !== 2'b00) begin
            err++; $display("FAIL taken_clear got=%b exp=00", {mem_pcsrc, mem_flush});
        end
        if_pc = 32'h40; #1;
        chk++;
        if (if_pred_taken !== 1'b1) begin
            err++; $display("FAIL taken_pred got=%b exp=1", if_pred_taken);
        end
    endtask

    task automatic test_saturate();
        if_pc = 32'h44;
        for (int k = 0; k < 4; k++) begin
            br(32'h44, COND_GTZ, 0, 0, model_pred(32'h44));
            tick();
            chk++;
            if (obs !== exp_vec()) begin
                err++; $display("FAIL sat_up%0d got=%h exp=%h", k, obs, exp_vec());
            end
        end
        for (int k = 0; k < 2; k++) begin
            br(32'h44, COND_NE, 1, 0, model_pred(32'h44));
            tick();
        end
        idle(); #1;
        chk++;
        if (if_pred_taken !== 1'b0) begin
            err++; $display("FAIL sat_down got=%b exp=0", if_pred_taken);
        end
    endtask

    task automatic test_stall();
        if_pc = 32'h48;
        br(32'h48, COND_EQ, 1, 0, 0);
        ex_stall = 1;
        tick();
        chk++;
        if ({mem_pcsrc, mem_flush, if_pred_taken} !== 3'b000) begin
            err++; $display("FAIL stall got=%b exp=000",
                            {mem_pcsrc, mem_flush, if_pred_taken});
        end
        ex_stall = 0;
        tick();
        idle();
        chk++;
        if (mem_pcsrc !== 1'b1) begin
            err++; $display("FAIL stall_release got=%b exp=1", mem_pcsrc);
        end
    endtask

    task automatic test_alias();
        if_pc = 32'h80;
        br(32'h40, COND_NEVER, 0, 0, 1);
        #1;
        chk++;
        if (if_pred_taken !== 1'b1) begin
            err++; $display("FAIL alias_old got=%b exp=1", if_pred_taken);
        end
        tick();
        idle(); #1;
        chk++;
        if ({if_pred_taken, mem_flush} !== 2'b01) begin
            err++; $display("FAIL alias_new got=%b exp=01", {if_pred_taken, mem_flush});
        end
    endtask

    task automatic test_mid_reset();
        if_pc = 32'h4C;
        br(32'h4C, COND_ALWAYS, 0, 0, 0);
        reset = 1;
        tick();
        idle(); #1;
        chk++;
        if (obs !== 11'd0) begin
            err++; $display("FAIL mid_reset got=%h exp=%h", obs, 11'd0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(39) == 0);
            ex_valid = 1'($urandom); ex_branch = 1'($urandom);
            ex_stall = ($urandom_range(3) == 0);
            ex_cond = 3'($urandom); ex_zero = 1'($urandom);
            ex_neg = 1'($urandom); ex_pred_taken = 1'($urandom);
            if_pc = $urandom;
            ex_pc = ($urandom_range(1) == 0) ? if_pc : $urandom;
            #1;
            chk++;
            if (obs !== exp_vec()) begin
                err++; $display("FAIL rand_pre%0d got=%h exp=%h", k, obs, exp_vec());
            end
            tick();
            chk++;
            if (obs !== exp_vec()) begin
                err++; $display("FAIL rand_post%0d got=%h exp=%h", k, obs, exp_vec());
            end
        end
        idle();
    endtask

    task automatic test_stats();
        logic [3:0] want;
        reset = 1; tick(); idle();
        for (int k = 0; k < 20; k++) begin
            br($urandom, COND_ALWAYS, 0, 0, 0);
            tick();
            chk++;
            if (obs !== exp_vec()) begin
                err++; $display("FAIL stats%0d got=%h exp=%h", k, obs, exp_vec());
            end
        end
        idle();
`ifdef BRU_STATS_EN
        want = 4'd15;
`else
        want = 4'd0;
`endif
        chk++;
        if ({stat_branches, stat_mispredicts} !== {want, want}) begin
            err++; $display("FAIL stats_sat got=%h/%h exp=%h",
                            stat_branches, stat_mispredicts, want);
        end
    endtask

    initial begin
        test_reset();
        test_taken();
        test_saturate();
        test_stall();
        test_alias();
        test_mid_reset();
        test_random();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
